frame_capture_tx: RTL

- Downstream consumer of the matrix scan controller.
- Captures one ADC sample per pixel for a full N_ROWS x N_COLS scan into a local frame buffer, in scan order.
- When the frame is complete, streams it byte-by-byte to the UART transmitter over a start/done handshake.
- Sits between the scan FSM/ADC interface and uart_tx.

---
 rtl/frame_capture_pkg.sv | 32 +++
 rtl/frame_capture_tx_mem.sv | 39 +++
 rtl/frame_capture_tx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/frame_capture_pkg.sv
// Shared types and sizing helpers for the frame capture / UART streaming block.
package frame_capture_pkg;

    // Controller states; encodings 6 and 7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Ceiling log2 with a floor of one bit so that degenerate sizes still
    // produce a legal vector width.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 32'd1;
        while ((32'd1 << r) < v) begin
            r = r + 32'd1;
        end
        return r;
    endfunction

    // Number of pixels in one frame.
    function automatic int unsigned npix_f(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/frame_capture_tx_mem.sv
// Frame buffer: one DATA_W word per pixel, synchronous write, registered read.
// The array itself has no reset; only the read register is cleared.
module frame_mem #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Sample storage; contents are don't-care until written by a capture.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    // Registered read port, updated only when a read is requested.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re_i) begin
            rdata_r <= mem_r[raddr_i];
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/frame_capture_tx.sv
// Captures one ADC sample per pixel into a local frame buffer, then streams
// the frame (header byte, then MSB/LSB byte pairs per sample) to uart_tx
// over a start/done handshake.
module frame_capture_tx
    import frame_capture_pkg::*;
#(
    parameter int unsigned N_ROWS = 2,
    parameter int unsigned N_COLS = 2,
    parameter int unsigned DATA_W = 12,
    parameter logic [7:0]  HEADER = HEADER_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              eoadc_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              tx_done_i,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              overrun_o
);

    localparam int unsigned NPIX   = npix_f(N_ROWS, N_COLS);
    localparam int unsigned PTR_W  = clog2_f(NPIX);
    localparam int unsigned BIDX_W = clog2_f(2 * NPIX + 1);

    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NPIX - 32'd1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(2 * NPIX);

    state_e              state_r, next_state_s;
    logic [PTR_W-1:0]    wr_ptr_r, wr_ptr_next_s;
    logic [BIDX_W-1:0]   byte_idx_r, byte_idx_next_s;
    logic                overrun_r, overrun_next_s;
    logic                tx_start_r;
    logic [7:0]          tx_data_r, tx_data_next_s;
    logic                frame_done_r;
    logic                mem_we_s;
    logic                mem_re_s;
    logic [PTR_W-1:0]    rd_addr_s;
    logic [DATA_W-1:0]   rdata_s;
    logic [15:0]         samp_ext_s;

    // Byte k>0 belongs to sample (k-1)/2; odd k is its MSB, even k its LSB.
    assign rd_addr_s  = PTR_W'((byte_idx_r - BIDX_W'(1)) >> 1);
    // Zero-extension makes the MSB byte all zeros when DATA_W <= 8.
    assign samp_ext_s = 16'(rdata_s);

    frame_mem #(
        .DEPTH  (NPIX),
        .DATA_W (DATA_W),
        .ADDR_W (PTR_W)
    ) u_frame_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (mem_we_s),
        .waddr_i (wr_ptr_r),
        .wdata_i (adc_data_i),
        .re_i    (mem_re_s),
        .raddr_i (rd_addr_s),
        .rdata_o (rdata_s)
    );

    // Next-state, counter and overrun logic for the capture/stream sequencer.
    always_comb begin
        next_state_s    = state_r;
        wr_ptr_next_s   = wr_ptr_r;
        byte_idx_next_s = byte_idx_r;
        overrun_next_s  = overrun_r;
        mem_we_s        = 1'b0;
        mem_re_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    // A start coinciding with a sample wins; the sample is dropped silently.
                    next_state_s   = ST_CAPTURE;
                    wr_ptr_next_s  = {PTR_W{1'b0}};
                    overrun_next_s = 1'b0;
                end else if (eoadc_i) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
            end
            ST_CAPTURE: begin
                if (eoadc_i) begin
                    mem_we_s = 1'b1;
                    if (wr_ptr_r == LAST_PTR) begin
                        next_state_s    = ST_LOAD;
                        byte_idx_next_s = {BIDX_W{1'b0}};
                    end else begin
                        wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
                    end
                end else begin
                    next_state_s = ST_CAPTURE;
                end
            end
            ST_LOAD: begin
                mem_re_s     = (byte_idx_r != {BIDX_W{1'b0}});
                next_state_s = ST_START;
                if (eoadc_i) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
            end
            ST_START: begin
                next_state_s = ST_WAIT_TX;
                if (eoadc_i) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
            end
            ST_WAIT_TX: begin
                if (tx_done_i) begin
                    if (byte_idx_r == LAST_BYTE) begin
                        next_state_s = ST_DONE;
                    end else begin
                        byte_idx_next_s = byte_idx_r + BIDX_W'(1);
                        next_state_s    = ST_LOAD;
                    end
                end else begin
                    next_state_s = ST_WAIT_TX;
                end
                if (eoadc_i) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
                if (eoadc_i) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
            end
            default: begin
                next_state_s    = ST_IDLE;
                wr_ptr_next_s   = {PTR_W{1'b0}};
                byte_idx_next_s = {BIDX_W{1'b0}};
                overrun_next_s  = 1'b0;
            end
        endcase
    end

    // Byte mux: the outgoing byte is latched while in START and then held
    // until the next START, so it is stable for the whole UART handshake.
    always_comb begin
        tx_data_next_s = tx_data_r;
        if (state_r == ST_START) begin
            if (byte_idx_r == {BIDX_W{1'b0}}) begin
                tx_data_next_s = HEADER;
            end else if (byte_idx_r[0]) begin
                tx_data_next_s = samp_ext_s[15:8];
            end else begin
                tx_data_next_s = samp_ext_s[7:0];
            end
        end else begin
            tx_data_next_s = tx_data_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {PTR_W{1'b0}};
            byte_idx_r   <= {BIDX_W{1'b0}};
            overrun_r    <= 1'b0;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            wr_ptr_r     <= wr_ptr_next_s;
            byte_idx_r   <= byte_idx_next_s;
            overrun_r    <= overrun_next_s;
            tx_start_r   <= (state_r == ST_START);
            tx_data_r    <= tx_data_next_s;
            frame_done_r <= (next_state_s == ST_DONE) && (state_r != ST_DONE);
        end
    end

    assign tx_start_o   = tx_start_r;
    assign tx_data_o    = tx_data_r;
    assign frame_done_o = frame_done_r;
    assign overrun_o    = overrun_r;
    assign busy_o       = (state_r != ST_IDLE);

endmodule
